sequential_bin_to_bcd: RTL and testbench
========================================

Name: sequential_bin_to_bcd

Overview:
Downstream display stage for the sequential multiplier. It converts the 2*N-bit binary product into packed BCD digits for the seven-segment/display path. The conversion is iterative shift-add-3 (double dabble): one bit per clock, with a start/busy/done handshake. The result is held stable between conversions, so the display logic can sample it at any time.

Parameters:
p_data_width, 14, width of the binary input (2*7 = multiplier product width).
p_digits, 5, number of BCD output digits. Must satisfy 10^p_digits > 2^p_data_width - 1 for overflow-free operation.

Ports:
i_w_clk  input  1  system clock, all state updates on the rising edge.
i_w_reset  input  1  synchronous, active-high reset.
i_w_start  input  1  request conversion of i_w_in; honoured only in IDLE.
i_w_in  input  p_data_width  binary value (multiplier product); sampled on the accepting edge only.
o_w_busy  output  1  high while a conversion is in progress or completing (state != IDLE).
o_w_done  output  1  one-cycle pulse: o_w_bcd holds a new result.
o_w_bcd  output  4*p_digits  packed BCD. Digit k occupies bits [4k+3:4k]; digit 0 is the units digit.
o_w_overflow  output  1  result did not fit in p_digits; valid with o_w_done, held until the next accepted start.

Behaviour:
- Interface: one clock, i_w_clk; reset i_w_reset is synchronous and active-high.
- Reset (i_w_reset=1 at an edge), regardless of state:
  - state=IDLE, internal shift/scratch/counter cleared.
  - o_w_bcd=0, o_w_overflow=0, o_w_done=0, o_w_busy=0.
  - Reset mid-conversion aborts the conversion. No done pulse follows.
- FSM states: IDLE, SHIFT, DONE. Encodings come from the shared package.
- IDLE:
  - With i_w_start=1 at an edge: latch i_w_in into the binary shift register, clear the BCD scratch and sticky overflow, load bit counter = p_data_width, go to SHIFT.
  - o_w_bcd and o_w_overflow keep their previous values until the new result is committed.
- SHIFT, each cycle (one iteration):
  - Every scratch digit >= 5 gets +3 (combinational).
  - Then {scratch, binary} shifts left by 1, MSB first.
  - If the bit shifted out of the top scratch digit is 1, set sticky overflow.
  - Decrement the counter.
- SHIFT exit: on the edge performing the final iteration (counter 1 -> 0):
  - Commit the adjusted/shifted scratch to o_w_bcd and the sticky flag to o_w_overflow.
  - Go to DONE.
- DONE: o_w_done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge 0; iterations at edges 1..p_data_width; o_w_done high during the cycle after edge p_data_width. Throughput is one conversion per p_data_width+2 cycles.
- o_w_busy is combinational from state: 1 in SHIFT and DONE.
- Simultaneous/ignored events:
  - i_w_start while busy (SHIFT or DONE) is ignored. It is not queued.
  - i_w_in changes after acceptance have no effect.
  - Reset has priority over start.
- Arithmetic:
  - The add-3 is applied per 4-bit digit and never carries between digits; inputs to the adjust are 0..9 by construction.
  - Zero input produces all-zero BCD, done as normal.
  - Maximum input 2^p_data_width-1 must convert exactly when the p_digits constraint holds.

Decomposition:
- Shared package:
  - FSM state localparams (STATE_IDLE=2'd0, STATE_SHIFT=2'd1, STATE_DONE=2'd2).
  - Default widths, shared with the multiplier: operand width 7, product width 14, BCD digit width 4.
- Sub-module: bcd_digit_adjust, combinational 4-bit "if >=5 add 3". Instantiated p_digits times via generate.
- Top holds the FSM, counter ($clog2(p_data_width+1) bits), shift registers, and output registers.

Test Plan:
- Reset, then start with i_w_in=16129 (127*127) -> busy high for 15 cycles; done pulses in the 15th cycle after the start edge; o_w_bcd=20'h16129, overflow=0.
- i_w_in=0 -> o_w_bcd=20'h00000 after the same latency; done pulses once only.
- i_w_in=16383 -> o_w_bcd=20'h16383. Then run with p_digits=4, i_w_in=16383 -> overflow=1; i_w_in=9999 -> 16'h9999, overflow=0.
- Start at 42, then pulse start with i_w_in=777 at cycles 3 and 15 after the start edge (SHIFT and DONE) -> both ignored; result 20'h00042; one done pulse; busy never drops mid-conversion.
- Start at 5000, assert reset at iteration 6 -> next cycle busy=0, o_w_bcd=0, no done pulse. A following start at 1234 yields 20'h01234.
- Back-to-back: start asserted in the first IDLE cycle after done -> accepted; previous o_w_bcd holds until the new commit.

Source files
------------

// File: rtl/sequential_bin_to_bcd_pkg.sv
// Shared definitions for the multiplier product display path.
package sequential_bin_to_bcd_pkg;

  // Widths shared with the sequential multiplier.
  localparam int unsigned OPERAND_WIDTH   = 7;
  localparam int unsigned PRODUCT_WIDTH   = 2 * OPERAND_WIDTH;
  localparam int unsigned BCD_DIGIT_WIDTH = 4;

  // Converter FSM encodings.
  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_SHIFT = 2'd1,
    STATE_DONE  = 2'd2
  } state_e;

  // True when p_digits decimal digits can hold every p_data_width-bit value.
  function automatic logic digits_sufficient(input int unsigned data_width,
                                             input int unsigned digits);
    logic [63:0] max_bin;
    logic [63:0] max_dec;
    max_bin = (64'd1 << data_width) - 64'd1;
    max_dec = 64'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      max_dec = max_dec * 64'd10;
    end
    return (max_dec > max_bin);
  endfunction

endpackage

// File: rtl/sequential_bin_to_bcd_adjust.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so the next
// left shift produces the correct decimal carry. No carry between digits.
module bcd_digit_adjust
  import sequential_bin_to_bcd_pkg::*;
(
  input  logic [BCD_DIGIT_WIDTH-1:0] i_digit,
  output logic [BCD_DIGIT_WIDTH-1:0] o_digit_c
);

  // Add 3 when the digit is five or more.
  always_comb begin
    o_digit_c = i_digit;
    if (i_digit >= BCD_DIGIT_WIDTH'(5)) begin
      o_digit_c = i_digit + BCD_DIGIT_WIDTH'(3);
    end
  end

endmodule

// File: rtl/sequential_bin_to_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per clock,
// with a start/busy/done handshake and a held result register.
module sequential_bin_to_bcd
  import sequential_bin_to_bcd_pkg::*;
#(
  parameter int unsigned p_data_width = PRODUCT_WIDTH,
  parameter int unsigned p_digits     = 5
) (
  input  logic                                i_w_clk,
  input  logic                                i_w_reset,
  input  logic                                i_w_start,
  input  logic [p_data_width-1:0]             i_w_in,
  output logic                                o_w_busy,
  output logic                                o_w_done,
  output logic [BCD_DIGIT_WIDTH*p_digits-1:0] o_w_bcd,
  output logic                                o_w_overflow
);

  localparam int unsigned BCD_W = BCD_DIGIT_WIDTH * p_digits;
  localparam int unsigned CNT_W = $clog2(p_data_width + 1);

  state_e             state_q, state_d;
  logic [p_data_width-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sticky_q, sticky_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]        adjusted_c;
  logic [BCD_W-1:0]        scratch_shift_c;
  logic [p_data_width-1:0] bin_shift_c;
  logic                    carry_out_c;

  // Per-digit add-3 correction ahead of each shift.
  for (genvar g = 0; g < p_digits; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit   (scratch_q[BCD_DIGIT_WIDTH*g +: BCD_DIGIT_WIDTH]),
      .o_digit_c (adjusted_c[BCD_DIGIT_WIDTH*g +: BCD_DIGIT_WIDTH])
    );
  end

  // One double-dabble step: {adjusted scratch, binary} shifted left by one.
  always_comb begin
    carry_out_c     = adjusted_c[BCD_W-1];
    scratch_shift_c = {adjusted_c[BCD_W-2:0], bin_q[p_data_width-1]};
    bin_shift_c     = {bin_q[p_data_width-2:0], 1'b0};
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state_q   <= STATE_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath control; results commit on the last iteration.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sticky_d  = sticky_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      STATE_IDLE: begin
        if (i_w_start) begin
          bin_d     = i_w_in;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_W'(p_data_width);
          state_d   = STATE_SHIFT;
        end
      end
      STATE_SHIFT: begin
        bin_d     = bin_shift_c;
        scratch_d = scratch_shift_c;
        sticky_d  = sticky_q | carry_out_c;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scratch_shift_c;
          ovf_d   = sticky_q | carry_out_c;
          done_d  = 1'b1;
          state_d = STATE_DONE;
        end
      end
      STATE_DONE: begin
        state_d = STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Busy follows state; done is the registered commit pulse.
  always_comb begin
    o_w_busy     = (state_q != STATE_IDLE);
    o_w_done     = done_q;
    o_w_bcd      = bcd_q;
    o_w_overflow = ovf_q;
  end

endmodule

// File: tb/tb_sequential_bin_to_bcd.sv
// Directed bench: 5-digit and 4-digit converters driven in parallel.
module tb_sequential_bin_to_bcd;

  logic        clk;
  logic        reset;
  logic        start;
  logic [13:0] din;
  logic        busy5, done5, ovf5;
  logic [19:0] bcd5;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;

  int checks;
  int errors;
  logic [19:0] prev5;

  typedef struct {
    logic [13:0] val;
    logic [19:0] e5;
    logic [15:0] e4;
    logic        o4;
    int          inj_a;
    int          inj_b;
  } vec_t;

  vec_t vecs [8];

  sequential_bin_to_bcd #(.p_data_width(14), .p_digits(5)) dut (
    .i_w_clk      (clk),
    .i_w_reset    (reset),
    .i_w_start    (start),
    .i_w_in       (din),
    .o_w_busy     (busy5),
    .o_w_done     (done5),
    .o_w_bcd      (bcd5),
    .o_w_overflow (ovf5)
  );

  sequential_bin_to_bcd #(.p_data_width(14), .p_digits(4)) dut4 (
    .i_w_clk      (clk),
    .i_w_reset    (reset),
    .i_w_start    (start),
    .i_w_in       (din),
    .o_w_busy     (busy4),
    .o_w_done     (done4),
    .o_w_bcd      (bcd4),
    .o_w_overflow (ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start a conversion now (sampled at the next edge) and follow it to IDLE.
  // Samples are taken 1 time unit after each edge; k counts edges after start.
  task automatic do_conv(input vec_t v);
    logic busy_ok;
    logic hold_ok;
    int   dones;
    int   done_at;
    logic busy_after;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    dones   = 0;
    done_at = -1;
    busy_after = 1'b0;
    start = 1'b1;
    din   = v.val;
    for (int k = 0; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        start = 1'b0;
      end
      din = 14'd777;
      if (k <= 14 && !busy5) busy_ok = 1'b0;
      if (k == 15) busy_after = busy5;
      if (done5) begin
        dones++;
        done_at = k;
      end
      if (k < 14 && bcd5 !== prev5) hold_ok = 1'b0;
      if (k == 14) begin
        check($sformatf("bcd5[%0d]", v.val), 32'(bcd5), 32'(v.e5));
        check($sformatf("ovf5[%0d]", v.val), 32'(ovf5), 32'(0));
        check($sformatf("bcd4[%0d]", v.val), 32'(bcd4), 32'(v.e4));
        check($sformatf("ovf4[%0d]", v.val), 32'(ovf4), 32'(v.o4));
      end
      start = (k == v.inj_a || k == v.inj_b);
    end
    start = 1'b0;
    check($sformatf("busy_held[%0d]", v.val), 32'(busy_ok), 32'(1));
    check($sformatf("busy_idle[%0d]", v.val), 32'(busy_after), 32'(0));
    check($sformatf("hold_prev[%0d]", v.val), 32'(hold_ok), 32'(1));
    check($sformatf("done_count[%0d]", v.val), 32'(dones), 32'(1));
    check($sformatf("done_cycle[%0d]", v.val), 32'(done_at), 32'(14));
    prev5 = v.e5;
  endtask

  initial begin
    vec_t r;
    int   stray_done;
    checks = 0;
    errors = 0;
    prev5  = '0;

    vecs[0] = '{val: 14'd16129, e5: 20'h16129, e4: 16'h6129, o4: 1'b1, inj_a: -1, inj_b: -1};
    vecs[1] = '{val: 14'd0,     e5: 20'h00000, e4: 16'h0000, o4: 1'b0, inj_a: -1, inj_b: -1};
    vecs[2] = '{val: 14'd16383, e5: 20'h16383, e4: 16'h6383, o4: 1'b1, inj_a: -1, inj_b: -1};
    vecs[3] = '{val: 14'd9999,  e5: 20'h09999, e4: 16'h9999, o4: 1'b0, inj_a: -1, inj_b: -1};
    vecs[4] = '{val: 14'd42,    e5: 20'h00042, e4: 16'h0042, o4: 1'b0, inj_a: 2,  inj_b: 14};
    vecs[5] = '{val: 14'd10000, e5: 20'h10000, e4: 16'h0000, o4: 1'b1, inj_a: -1, inj_b: -1};
    vecs[6] = '{val: 14'd8191,  e5: 20'h08191, e4: 16'h8191, o4: 1'b0, inj_a: -1, inj_b: -1};
    vecs[7] = '{val: 14'd1,     e5: 20'h00001, e4: 16'h0001, o4: 1'b0, inj_a: -1, inj_b: -1};

    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy5), 32'(0));
    check("rst_done", 32'(done5), 32'(0));
    check("rst_bcd", 32'(bcd5), 32'(0));
    check("rst_ovf", 32'(ovf5), 32'(0));
    check("rst_ovf4", 32'(ovf4), 32'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Vectors run back to back: each start lands in the first IDLE cycle.
    for (int i = 0; i < 8; i++) begin
      do_conv(vecs[i]);
    end

    // Reset sampled at the sixth iteration edge aborts the conversion.
    start = 1'b1;
    din   = 14'd5000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy5), 32'(0));
    check("abort_bcd", 32'(bcd5), 32'(0));
    check("abort_done", 32'(done5), 32'(0));
    check("abort_ovf4", 32'(ovf4), 32'(0));
    reset = 1'b0;
    stray_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done5 || busy5) stray_done++;
    end
    check("abort_quiet", 32'(stray_done), 32'(0));
    prev5 = '0;

    r = '{val: 14'd1234, e5: 20'h01234, e4: 16'h1234, o4: 1'b0, inj_a: -1, inj_b: -1};
    do_conv(r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
